// File: rtl/keypad_scan_unit.sv
// rtl/keypad_scan_unit.sv - 3x3 keypad column scanner with frame debounce and 7-seg key display
module keypad_scan_unit #(
    parameter logic [27:0] SCAN_MAX = 28'd49_999,
    parameter int          DEBOUNCE = 3
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [2:0] row_n,
    output logic [2:0] column_n,
    output logic [3:0] key,
    output logic       valid_key,
    output logic       key_down,
    output logic [6:0] hex,
    output logic       scan_tick
);

    logic [27:0] cnt_q, cnt_d;
    logic [2:0]  row_s1_q, row_s2_q;
    logic [1:0]  col_q, col_d;
    logic [2:0]  samp0_q, samp0_d, samp1_q, samp1_d;
    logic [3:0]  prev_q, prev_d;
    logic [3:0]  stable_q, stable_d;
    logic [3:0]  key_q, key_d;
    logic        valid_q, valid_d;
    logic        kd_q, kd_d;
    logic [6:0]  hex_q, hex_d;

    logic [8:0]  frame_hit;
    logic [3:0]  frame_key;
    logic [3:0]  stable_nxt;
    logic [3:0]  accepted;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    assign scan_tick = (cnt_q == 28'd0);
    assign column_n  = ~(3'b001 << col_q);
    assign key       = key_q;
    assign valid_key = valid_q;
    assign key_down  = kd_q;
    assign hex       = hex_q;

    // Column 2 is never stored: its sample is the live synchronized row at the frame-closing tick.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            frame_hit[r*3]     = ~samp0_q[r];
            frame_hit[r*3 + 1] = ~samp1_q[r];
            frame_hit[r*3 + 2] = ~row_s2_q[r];
        end
        frame_key = 4'hF;
        for (int i = 8; i >= 0; i--) begin
            if (frame_hit[i]) frame_key = 4'(i);
        end
        if (frame_key == prev_q) stable_nxt = (stable_q == 4'd15) ? 4'd15 : stable_q + 4'd1;
        else                     stable_nxt = 4'd1;
        accepted = valid_q ? key_q : 4'hF;
    end

    always_comb begin
        cnt_d    = (cnt_q == 28'd0) ? SCAN_MAX : cnt_q - 28'd1;
        col_d    = col_q;
        samp0_d  = samp0_q;
        samp1_d  = samp1_q;
        prev_d   = prev_q;
        stable_d = stable_q;
        key_d    = key_q;
        valid_d  = valid_q;
        kd_d     = 1'b0;
        hex_d    = hex_q;
        if (scan_tick) begin
            case (col_q)
                2'd0: begin
                    samp0_d = row_s2_q;
                    col_d   = 2'd1;
                end
                2'd1: begin
                    samp1_d = row_s2_q;
                    col_d   = 2'd2;
                end
                default: begin
                    col_d    = 2'd0;
                    prev_d   = frame_key;
                    stable_d = stable_nxt;
                    if (stable_nxt == 4'(DEBOUNCE) && frame_key != accepted) begin
                        if (frame_key != 4'hF) begin
                            key_d   = frame_key;
                            valid_d = 1'b1;
                            kd_d    = 1'b1;
                            hex_d   = seg_decode(frame_key);
                        end else begin
                            valid_d = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            cnt_q    <= SCAN_MAX;
            row_s1_q <= 3'b111;
            row_s2_q <= 3'b111;
            col_q    <= 2'd0;
            samp0_q  <= 3'b111;
            samp1_q  <= 3'b111;
            prev_q   <= 4'hF;
            stable_q <= 4'd0;
            key_q    <= 4'hF;
            valid_q  <= 1'b0;
            kd_q     <= 1'b0;
            hex_q    <= 7'b1111111;
        end else begin
            cnt_q    <= cnt_d;
            row_s1_q <= row_n;
            row_s2_q <= row_s1_q;
            col_q    <= col_d;
            samp0_q  <= samp0_d;
            samp1_q  <= samp1_d;
            prev_q   <= prev_d;
            stable_q <= stable_d;
            key_q    <= key_d;
            valid_q  <= valid_d;
            kd_q     <= kd_d;
            hex_q    <= hex_d;
        end
    end

endmodule

// File: tb/tb_keypad_scan_unit.sv
// tb/tb_keypad_scan_unit.sv - self-checking bench for keypad_scan_unit with a keypad matrix model
module tb_keypad_scan_unit;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b0;
    logic [2:0] row_n;
    logic [2:0] column_n;
    logic [3:0] key;
    logic       valid_key;
    logic       key_down;
    logic [6:0] hex;
    logic       scan_tick;

    logic [8:0] pressed = 9'h000;

    int checks   = 0;
    int failures = 0;

    // Frame-level reference state
    int         m_prev;
    int         m_run;
    int         m_acc;
    logic [3:0] m_key;
    logic       m_valid;
    logic       m_kd;

    typedef struct {
        logic [8:0] p;
        logic [3:0] k;
        logic       v;
        logic       kd;
        logic [6:0] h;
    } vec_t;

    vec_t tbl[15];

    keypad_scan_unit #(.SCAN_MAX(28'd3), .DEBOUNCE(2)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .row_n    (row_n),
        .column_n (column_n),
        .key      (key),
        .valid_key(valid_key),
        .key_down (key_down),
        .hex      (hex),
        .scan_tick(scan_tick)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // A physical switch matrix: a row reads low when a pressed key sits on a driven column.
    always_comb begin
        row_n = 3'b111;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                if (!column_n[c] && pressed[r*3 + c]) row_n[r] = 1'b0;
    end

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
              7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
        return t[v];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev  = 15;
        m_run   = 0;
        m_acc   = -1;
        m_key   = 4'hF;
        m_valid = 1'b0;
        m_kd    = 1'b0;
    endtask

    task automatic model_frame(input logic [8:0] p);
        int fk;
        fk = 15;
        for (int i = 0; i < 9; i++)
            if (p[i] && fk == 15) fk = i;
        m_run  = (fk == m_prev) ? ((m_run >= 15) ? 15 : m_run + 1) : 1;
        m_prev = fk;
        m_kd   = 1'b0;
        if (m_run == 2 && fk != ((m_acc < 0) ? 15 : m_acc)) begin
            if (fk != 15) begin
                m_acc   = fk;
                m_key   = 4'(fk);
                m_valid = 1'b1;
                m_kd    = 1'b1;
            end else begin
                m_acc   = -1;
                m_valid = 1'b0;
            end
        end
    endtask

    // Starts at a negedge on a frame boundary, ends at the negedge after the frame-closing edge.
    task automatic run_frame(input logic [8:0] p);
        logic [2:0] ec;
        pressed = p;
        for (int j = 1; j <= 12; j++) begin
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            ec = ~(3'b001 << ((j / 4) % 3));
            chk("column_n", 32'(column_n), 32'(ec));
            chk("scan_tick", 32'(scan_tick), 32'((j % 4) == 3));
            if (j < 12) chk("key_down_idle", 32'(key_down), 32'd0);
        end
        model_frame(p);
        chk("key", 32'(key), 32'(m_key));
        chk("valid_key", 32'(valid_key), 32'(m_valid));
        chk("key_down", 32'(key_down), 32'(m_kd));
        chk("hex", 32'(hex), 32'(seg_of(m_key)));
    endtask

    initial begin
        tbl[0]  = '{9'h000, 4'hF, 1'b0, 1'b0, 7'b1111111};
        tbl[1]  = '{9'h010, 4'hF, 1'b0, 1'b0, 7'b1111111};
        tbl[2]  = '{9'h010, 4'h4, 1'b1, 1'b1, 7'b0011001};
        tbl[3]  = '{9'h010, 4'h4, 1'b1, 1'b0, 7'b0011001};
        tbl[4]  = '{9'h000, 4'h4, 1'b1, 1'b0, 7'b0011001};
        tbl[5]  = '{9'h000, 4'h4, 1'b0, 1'b0, 7'b0011001};
        tbl[6]  = '{9'h080, 4'h4, 1'b0, 1'b0, 7'b0011001};
        tbl[7]  = '{9'h000, 4'h4, 1'b0, 1'b0, 7'b0011001};
        tbl[8]  = '{9'h000, 4'h4, 1'b0, 1'b0, 7'b0011001};
        tbl[9]  = '{9'h044, 4'h4, 1'b0, 1'b0, 7'b0011001};
        tbl[10] = '{9'h044, 4'h2, 1'b1, 1'b1, 7'b0100100};
        tbl[11] = '{9'h040, 4'h2, 1'b1, 1'b0, 7'b0100100};
        tbl[12] = '{9'h040, 4'h6, 1'b1, 1'b1, 7'b0000010};
        tbl[13] = '{9'h001, 4'h6, 1'b1, 1'b0, 7'b0000010};
        tbl[14] = '{9'h001, 4'h0, 1'b1, 1'b1, 7'b1000000};

        model_reset();
        repeat (3) @(negedge CLOCK_50);
        chk("rst_column_n", 32'(column_n), 32'(3'b110));
        chk("rst_key", 32'(key), 32'hF);
        chk("rst_valid_key", 32'(valid_key), 32'd0);
        chk("rst_key_down", 32'(key_down), 32'd0);
        chk("rst_hex", 32'(hex), 32'(7'b1111111));
        chk("rst_scan_tick", 32'(scan_tick), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_frame(tbl[i].p);
            chk("tbl_key", 32'(key), 32'(tbl[i].k));
            chk("tbl_valid", 32'(valid_key), 32'(tbl[i].v));
            chk("tbl_key_down", 32'(key_down), 32'(tbl[i].kd));
            chk("tbl_hex", 32'(hex), 32'(tbl[i].h));
        end

        // Key 0 held 20 frames in total: never re-pulses, display stays on 0
        repeat (18) begin
            run_frame(9'h001);
            chk("held_hex", 32'(hex), 32'(7'b1000000));
        end

        run_frame(9'h100);
        run_frame(9'h100);
        chk("k8_key", 32'(key), 32'h8);
        chk("k8_valid", 32'(valid_key), 32'd1);

        // Asynchronous reset in the middle of a frame while key 8 is held
        repeat (5) @(posedge CLOCK_50);
        #2 reset = 1'b0;
        #1;
        chk("arst_key", 32'(key), 32'hF);
        chk("arst_hex", 32'(hex), 32'(7'b1111111));
        chk("arst_valid", 32'(valid_key), 32'd0);
        chk("arst_column_n", 32'(column_n), 32'(3'b110));
        chk("arst_key_down", 32'(key_down), 32'd0);
        pressed = 9'h000;
        model_reset();
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b1;

        repeat (30) begin
            logic [8:0] p;
            int         sel;
            sel = int'($urandom_range(0, 3));
            if (sel == 0)      p = 9'h000;
            else if (sel == 3) p = (9'h001 << $urandom_range(0, 8)) | (9'h001 << $urandom_range(0, 8));
            else               p = 9'h001 << $urandom_range(0, 8);
            repeat ($urandom_range(1, 4)) run_frame(p);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scan_unit.md
# keypad_scan_unit

Keypad front end for the whack-a-mole game: scans the 3×3 key matrix, debounces it, and reports the pressed key index (0–8) to the hit-recording logic. A column-scan clock divider sets the scan rate. A BCD-to-seven-segment decoder shows the last accepted key on one display digit. It sits between the GPIO expansion header (rows in, columns out) and the game core, which compares `key` against the lit light position.

## Interface

Parameters:
- SCAN_MAX, default 28'd49_999: divider reload value; one scan tick every SCAN_MAX+1 clocks (1 ms at 50 MHz). Legal range ≥ 3.
- DEBOUNCE, default 3: number of consecutive identical scan frames needed to accept a key state. Legal range 1–15.

Ports:
- CLOCK_50, input, 1: system clock; all logic on its rising edge.
- reset, input, 1: reset, asynchronous, active-low.
- row_n, input, 3: matrix rows, active-low (pulled up; 0 = key on the driven column pressed).
- column_n, output, 3: matrix columns, one-hot active-low drive.
- key, output, 4: index of the last accepted key, computed as row*3+col (0–8); 4'hF = none since reset.
- valid_key, output, 1: high while an accepted key is held.
- key_down, output, 1: one-clock pulse on each key acceptance.
- hex, output, 7: {g,f,e,d,c,b,a}, active-low segment pattern of `key`.
- scan_tick, output, 1: divider tick (counter == 0), exported for debug.

## Operation

- Divider: 28-bit down-counter.
  - Reset loads SCAN_MAX.
  - Each clock: if the counter is 0, reload SCAN_MAX; otherwise decrement.
  - scan_tick = (counter == 0), combinational.
- Row input passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- Column scan:
  - col index 0→1→2→0, advancing on each tick edge.
  - column_n = ~(1 << col).
  - On the tick edge, the synchronized row_n is sampled for the current col before it advances.
- Frame: the three samples col0..col2.
  - At the col2 tick edge, frame_key = lowest index row*3+col with row_n bit = 0; 4'hF if no key is pressed.
  - With multiple keys pressed, the lowest index wins.
- Debounce:
  - If frame_key equals the previous frame_key, stable_cnt increments, saturating at 15. Otherwise stable_cnt = 1.
  - The state is accepted on the frame where stable_cnt reaches DEBOUNCE.
- Acceptance, when the accepted frame_key differs from the currently accepted state:
  - Key (frame_key ≠ F): key ← frame_key, valid_key ← 1, key_down ← 1 for one cycle, hex ← decode(frame_key).
  - No key: valid_key ← 0. key and hex hold their last value.
  - Direct change from key A to key B, both stable: treated as a new press of B (key_down pulses).
- A held key never re-pulses key_down.
- hex decode (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10–15 = 1111111 (blank)

## Timing

- Reset values:
  - divider counter = SCAN_MAX, scan_tick = 0 (unless SCAN_MAX = 0).
  - col = 0, column_n = 3'b110.
  - key = 4'hF, valid_key = 0, key_down = 0, hex = 7'b1111111.
  - stable_cnt = 0, previous frame_key = 4'hF, accepted state = none.
- Reset mid-operation: all of the above apply immediately (asynchronous), including mid-frame and while a key is held.
- The first tick occurs SCAN_MAX clocks after reset release. Ticks then repeat every SCAN_MAX+1 clocks. A frame spans 3 ticks.
- Outputs key, valid_key, key_down and hex update on the col2 tick edge that completes the DEBOUNCE-th stable frame. key_down falls on the next edge.
- Press-to-key_down latency: at most (DEBOUNCE+1) frames plus 2 clocks (synchronizer).
- Row changes shorter than DEBOUNCE frames produce no output change.
- key and hex are registered; valid_key and key_down are registered; scan_tick is combinational.

## Test plan

All scenarios use SCAN_MAX=3 and DEBOUNCE=2 (tick every 4 clocks, frame 12 clocks).

- Reset check: hold reset=0, then release → column_n=110, key=F, valid_key=0, key_down=0, hex=1111111. column_n steps 101 then 011 at 4-clock intervals, then returns to 110.
- Single press: pull row_n[1] low only while column_n=101 (key 4), for ≥ 3 frames → exactly one key_down pulse, key=4, valid_key=1, hex=0011001. Release → valid_key=0 two frames later; key stays 4.
- Bounce rejection: assert key 7 for 1 frame, then release → no key_down, key unchanged.
- Multiple keys: press keys 2 and 6 together → key=2. Then release key 2 while holding 6 → second key_down pulse, key=6.
- Held key: hold key 0 for 20 frames → exactly one key_down pulse, hex=1000000 throughout.
- Async reset while key 8 is accepted → key=F, hex blank, valid_key=0 immediately, without waiting for a clock edge.
